// File: rtl/data_mem_pkg.sv
// Shared constants for the data-side memory responder: I/O address map and STATUS layout.
package data_mem_pkg;

  localparam logic [31:0] IO_BASE     = 32'h0001_0000;
  localparam logic [31:0] ADDR_TXDATA = IO_BASE;
  localparam logic [31:0] ADDR_STATUS = IO_BASE + 32'h4;
  localparam logic [31:0] ADDR_CYCLE  = IO_BASE + 32'h8;

  localparam int unsigned OVF_BIT   = 12;
  localparam int unsigned COUNT_LSB = 0;
  localparam int unsigned COUNT_W   = 12;

  typedef enum logic [2:0] {
    RG_NONE,
    RG_RAM,
    RG_TXDATA,
    RG_STATUS,
    RG_CYCLE
  } region_e;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module tx_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  // Storage is not reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage data responder: word RAM plus TXDATA/STATUS/CYCLE I/O registers, single-cycle access.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  region_e       region;
  logic          overflow;
  logic [31:0]   cycle_cnt;
  logic [31:0]   status_word;
  logic          push_req;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [1:0]    addr_lsb_unused;

  assign addr_lsb_unused = mem_addr[1:0];

  // I/O registers are matched first so the decode stays unambiguous for any RAM_WORDS.
  always_comb begin
    region = RG_NONE;
    if (mem_addr[31:2] == ADDR_TXDATA[31:2])
      region = RG_TXDATA;
    else if (mem_addr[31:2] == ADDR_STATUS[31:2])
      region = RG_STATUS;
    else if (mem_addr[31:2] == ADDR_CYCLE[31:2])
      region = RG_CYCLE;
    else if (mem_addr[31:AW+2] == '0)
      region = RG_RAM;
  end

  always_ff @(posedge clk) begin
    if (mem_we && region == RG_RAM) ram[mem_addr[AW+1:2]] <= mem_wdata;
  end

  assign push_req = mem_we & (region == RG_TXDATA);
  assign pop      = ~fifo_empty & tx_ready;
  assign tx_valid = ~fifo_empty;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (mem_wdata),
    .pop       (pop),
    .head_data (tx_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (mem_we && region == RG_STATUS)
        overflow <= 1'b0;
      else if (push_req && fifo_full && !pop)
        overflow <= 1'b1;

      if (mem_we && region == RG_CYCLE)
        cycle_cnt <= '0;
      else
        cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  always_comb begin
    status_word                       = '0;
    status_word[OVF_BIT]              = overflow;
    status_word[COUNT_LSB +: COUNT_W] = COUNT_W'(fifo_count);
  end

  always_comb begin
    case (region)
      RG_RAM:    mem_rdata = ram[mem_addr[AW+1:2]];
      RG_STATUS: mem_rdata = status_word;
      RG_CYCLE:  mem_rdata = cycle_cnt;
      default:   mem_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: queue/array reference model checked every cycle, plus directed literal checks.
module tb_data_mem_responder;

  localparam int unsigned RW = 1024;
  localparam int unsigned FD = 8;

  localparam logic [31:0] A_TX  = 32'h0001_0000;
  localparam logic [31:0] A_ST  = 32'h0001_0004;
  localparam logic [31:0] A_CYC = 32'h0001_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = A_ST;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready = 1'b0;

  int errs = 0;
  int chks = 0;
  bit cmp_en = 1'b1;

  logic [31:0] q_m[$];
  logic [31:0] ram_m [int unsigned];
  logic        ovf_m = 1'b0;
  logic [31:0] cyc_m = '0;

  data_mem_responder #(
    .RAM_WORDS  (RW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, pop before push so a full FIFO with a pop has room.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_m.delete();
      ovf_m = 1'b0;
      cyc_m = '0;
    end else begin
      if (tx_ready && q_m.size() != 0) void'(q_m.pop_front());
      if (mem_we && mem_addr[31:2] == A_TX[31:2]) begin
        if (q_m.size() < FD) q_m.push_back(mem_wdata);
        else ovf_m = 1'b1;
      end
      if (mem_we && mem_addr[31:2] == A_ST[31:2]) ovf_m = 1'b0;
      if (mem_we && mem_addr[31:2] == A_CYC[31:2]) cyc_m = '0;
      else cyc_m = cyc_m + 32'd1;
    end
    if (clk && mem_we && mem_addr < RW * 4) ram_m[mem_addr >> 2] = mem_wdata;
  end

  always begin
    logic [31:0] exp_rd;
    bit          known;
    @(negedge clk);
    #2;
    if (cmp_en) begin
      known  = 1'b1;
      exp_rd = '0;
      if (mem_addr[31:2] == A_TX[31:2])
        exp_rd = '0;
      else if (mem_addr[31:2] == A_ST[31:2])
        exp_rd = {19'b0, ovf_m, 12'(q_m.size())};
      else if (mem_addr[31:2] == A_CYC[31:2])
        exp_rd = cyc_m;
      else if (mem_addr < RW * 4) begin
        if (ram_m.exists(mem_addr >> 2)) exp_rd = ram_m[mem_addr >> 2];
        else known = 1'b0;
      end
      check("model_tx_valid", {31'b0, tx_valid}, {31'b0, q_m.size() != 0});
      check("model_tx_data", tx_data, (q_m.size() != 0) ? q_m[0] : 32'h0);
      if (known) check("model_rdata", mem_rdata, exp_rd);
    end
  end

  task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic rdy);
    @(negedge clk);
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wd;
    tx_ready  = rdy;
    #1;
  endtask

  initial begin
    logic [31:0] exp_list [8];

    // Reset state
    step(0, A_ST, 0, 0);
    check("rst_status", mem_rdata, 32'h0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_tx_data", tx_data, 32'h0);
    step(0, A_CYC, 0, 0);
    check("rst_cycle", mem_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("cycle_at_deassert", mem_rdata, 32'h0);
    step(0, A_CYC, 0, 0);
    check("cycle_after_1", mem_rdata, 32'h1);

    // RAM read-during-write returns the old word
    step(1, 32'h10, 32'h1111_1111, 0);
    step(1, 32'h10, 32'hDEAD_BEEF, 0);
    check("ram_old", mem_rdata, 32'h1111_1111);
    step(0, 32'h13, 0, 0);
    check("ram_new", mem_rdata, 32'hDEAD_BEEF);
    step(0, 32'h0002_0000, 0, 0);
    check("unmapped", mem_rdata, 32'h0);
    step(1, 32'h0002_0000, 32'h1234_5678, 0);
    step(0, 32'h0001_000C, 0, 0);
    check("unmapped_io", mem_rdata, 32'h0);

    // Overfill then drain in order
    for (int i = 1; i <= 9; i++) step(1, A_TX, 32'(i), 0);
    step(0, A_ST, 0, 0);
    check("status_full_ovf", mem_rdata, 32'h0000_1008);
    check("full_head", tx_data, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      step(0, A_ST, 0, 1);
      check("drain_data", tx_data, 32'(i));
      check("drain_valid", {31'b0, tx_valid}, 32'h1);
    end
    step(0, A_ST, 0, 0);
    check("drained_valid", {31'b0, tx_valid}, 32'h0);
    check("ovf_sticky", mem_rdata, 32'h0000_1000);
    step(1, A_ST, 32'hFFFF_FFFF, 0);
    step(0, A_ST, 0, 0);
    check("status_cleared", mem_rdata, 32'h0);

    // Full with simultaneous pop accepts the push
    for (int i = 0; i < 8; i++) step(1, A_TX, 32'h100 + 32'(i), 0);
    step(1, A_TX, 32'hAA, 1);
    check("fullpop_head", tx_data, 32'h100);
    step(0, A_ST, 0, 0);
    check("fullpop_status", mem_rdata, 32'h0000_0008);
    for (int i = 0; i < 7; i++) exp_list[i] = 32'h101 + 32'(i);
    exp_list[7] = 32'hAA;
    for (int i = 0; i < 8; i++) begin
      step(0, A_ST, 0, 1);
      check("fullpop_drain", tx_data, exp_list[i]);
    end
    step(0, A_ST, 0, 0);
    check("fullpop_empty", {31'b0, tx_valid}, 32'h0);

    // Push into empty with tx_ready high
    step(1, A_TX, 32'h55, 1);
    check("empty_push_valid0", {31'b0, tx_valid}, 32'h0);
    step(0, A_ST, 0, 1);
    check("empty_push_valid1", {31'b0, tx_valid}, 32'h1);
    check("empty_push_data", tx_data, 32'h55);
    step(0, A_ST, 0, 0);
    check("empty_push_popped", {31'b0, tx_valid}, 32'h0);

    // Cycle counter clear at 100
    for (int k = 0; k < 200 && cyc_m != 32'd100; k++) step(0, A_CYC, 0, 0);
    check("cycle_100", mem_rdata, 32'd100);
    step(1, A_CYC, 32'h5, 0);
    check("cycle_101_before_clear", mem_rdata, 32'd101);
    step(0, A_CYC, 0, 0);
    check("cycle_cleared", mem_rdata, 32'd0);
    step(0, A_CYC, 0, 0);
    check("cycle_after_clear", mem_rdata, 32'd1);

    // Cycle counter wrap
    step(0, A_CYC, 0, 0);
    #2;
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    cyc_m = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    step(0, A_CYC, 0, 0);
    check("cycle_max", mem_rdata, 32'hFFFF_FFFF);
    step(0, A_CYC, 0, 0);
    check("cycle_wrap", mem_rdata, 32'h0);
    step(0, A_CYC, 0, 0);
    check("cycle_wrap1", mem_rdata, 32'h1);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) step(1, A_TX, 32'h300 + 32'(i), 0);
    step(0, A_ST, 0, 0);
    check("pre_rst_status", mem_rdata, 32'h3);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid", {31'b0, tx_valid}, 32'h0);
    check("midrst_data", tx_data, 32'h0);
    check("midrst_status", mem_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(0, A_ST, 0, 1);
    check("postrst_status", mem_rdata, 32'h0);
    check("postrst_valid", {31'b0, tx_valid}, 32'h0);
    step(0, A_ST, 0, 0);

    cmp_en = 1'b0;
    #20;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
